pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 144 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - load-use stall, branch flush and debug halt/step control for a 5-stage pipeline
module pipeline_hazard_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_valid,
    input  logic        branch_taken,
    input  logic        halt_req,
    input  logic        id_halt_instr,
    input  logic        step_req,
    input  logic        resume_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LU_HOLD = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_t state;
    state_t state_next;
    logic   load_use;
    logic   halt_in;

    // Hazard detection: a load writing a non-zero register that ID is about to read
    always_comb begin
        load_use = ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        halt_in  = halt_req || id_halt_instr;
    end

    // Next state and pipeline control; branch beats load-use beats halt
    always_comb begin
        state_next  = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = ST_LU_HOLD;
                end else if (halt_in) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_next  = ST_HALTED;
                end
            end

            // The stalled load has moved on, so a repeat match here is the
            // same hazard and must not bubble twice.
            ST_LU_HOLD: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_next  = ST_RUN;
                end else if (halt_in) begin
                    state_next  = ST_HALTED;
                end else begin
                    state_next  = ST_RUN;
                end
            end

            ST_HALTED: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                if (resume_req) begin
                    state_next = ST_RUN;
                end else if (step_req) begin
                    state_next = ST_STEP;
                end
            end

            // One instruction's worth of RUN behaviour, then back to HALTED
            // no matter what happened during that cycle.
            ST_STEP: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
                state_next = ST_HALTED;
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase

        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_next  = ST_RUN;
        end
    end

    // State register with the halted flag tracking the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALTED) || (state_next == ST_STEP);
        end
    end

    // Saturating count of cycles the pipeline front end was frozen while not halted
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (state != ST_HALTED) && (stall_count != STALL_MAX)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - vector table and scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_valid;
    logic        branch_taken;
    logic        halt_req;
    logic        id_halt_instr;
    logic        step_req;
    logic        resume_req;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_controller dut (
        .clock        (clock),
        .reset        (reset),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_valid     (id_valid),
        .branch_taken (branch_taken),
        .halt_req     (halt_req),
        .id_halt_instr(id_halt_instr),
        .step_req     (step_req),
        .resume_req   (resume_req),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .stall_count  (stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       mr;
        logic [4:0] ert;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       v;
        logic       br;
        logic       hr;
        logic       hi;
        logic       st;
        logic       rsm;
        logic [3:0] ctl;
        logic       h;
        logic       stl;
    } vec_t;

    typedef struct {
        logic [3:0]  ctl;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [3:0] N = 4'b1100;
    localparam logic [3:0] S = 4'b0001;
    localparam logic [3:0] F = 4'b1111;
    localparam logic [3:0] R = 4'b0011;

    vec_t vecs[$];
    exp_t sb[$];
    logic [15:0] cnt_model = 16'd0;

    function automatic vec_t vin(input logic rst, input logic mr, input logic [4:0] ert,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                                 input logic v, input logic br, input logic hr, input logic hi,
                                 input logic st, input logic rsm, input logic [3:0] ctl,
                                 input logic h, input logic stl);
        vec_t t;
        t.rst = rst; t.mr = mr; t.ert = ert; t.rs = rs; t.rt = rt; t.ur = ur; t.v = v;
        t.br = br; t.hr = hr; t.hi = hi; t.st = st; t.rsm = rsm;
        t.ctl = ctl; t.h = h; t.stl = stl;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset = t.rst; ex_mem_read = t.mr; ex_rt = t.ert; id_rs = t.rs; id_rt = t.rt;
        id_uses_rt = t.ur; id_valid = t.v; branch_taken = t.br; halt_req = t.hr;
        id_halt_instr = t.hi; step_req = t.st; resume_req = t.rsm;
    endtask

    task automatic check1(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, req);
        end
    endtask

    task automatic compare_front(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
            return;
        end
        e = sb.pop_front();
        check1("pc_write",    idx, {15'd0, pc_write},    {15'd0, e.ctl[3]});
        check1("ifid_write",  idx, {15'd0, ifid_write},  {15'd0, e.ctl[2]});
        check1("ifid_flush",  idx, {15'd0, ifid_flush},  {15'd0, e.ctl[1]});
        check1("idex_bubble", idx, {15'd0, idex_bubble}, {15'd0, e.ctl[0]});
        check1("halted",      idx, {15'd0, halted},      {15'd0, e.h});
        check1("stall_count", idx, stall_count,          e.cnt);
    endtask

    initial begin
        vec_t idle;
        exp_t e;
        idle = vin(0,0,0,0,0,0,0,0,0,0,0,0,N,0,0);
        drive(idle);
        reset = 1'b1;

        //          rst mr ert rs rt ur v br hr hi st rsm ctl h stl
        vecs.push_back(vin(1,0,0,0,0,0,0,0,0,0,0,0,R,0,0));   // 0 reset forces flush/bubble
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 1 normal run
        vecs.push_back(vin(0,1,5,5,0,0,1,0,0,0,0,0,S,0,1));   // 2 load-use on rs
        vecs.push_back(vin(0,1,5,5,0,0,1,0,0,0,0,0,N,0,0));   // 3 second cycle: one bubble only
        vecs.push_back(vin(0,1,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 4 register zero never stalls
        vecs.push_back(vin(0,1,7,3,7,0,1,0,0,0,0,0,N,0,0));   // 5 rt match but rt unused
        vecs.push_back(vin(0,1,7,3,7,1,1,0,0,0,0,0,S,0,1));   // 6 rt match, rt used
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 7 hold -> run
        vecs.push_back(vin(0,1,5,5,0,0,0,0,0,0,0,0,N,0,0));   // 8 ID is a NOP
        vecs.push_back(vin(0,1,5,5,0,0,1,1,0,0,0,0,F,0,0));   // 9 branch beats load-use
        vecs.push_back(vin(0,1,5,5,0,0,1,0,0,0,0,0,S,0,1));   // 10 still in RUN after branch
        vecs.push_back(vin(0,0,0,0,0,0,1,1,0,0,0,0,F,0,0));   // 11 branch in hold
        vecs.push_back(vin(0,0,0,0,0,0,1,0,1,0,0,0,S,0,1));   // 12 halt pulse
        vecs.push_back(vin(0,1,5,5,0,0,1,1,0,0,0,0,S,1,0));   // 13 halted ignores branch/load
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,1,0,S,1,0));   // 14 step request
        vecs.push_back(vin(0,0,0,0,0,0,1,0,1,0,0,0,N,1,0));   // 15 step cycle ignores halt
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,S,1,0));   // 16 back in halted
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,1,1,S,1,0));   // 17 resume wins over step
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 18 running
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,1,0,N,0,0));   // 19 step ignored in run
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,1,0,0,S,0,1));   // 20 HALT opcode
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,1,0,S,1,0));   // 21 step
        vecs.push_back(vin(0,1,5,5,0,0,1,0,0,0,0,0,S,1,1));   // 22 step cycle is a load stall
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,S,1,0));   // 23 halted again
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,1,S,1,0));   // 24 resume
        vecs.push_back(vin(0,1,5,5,0,0,1,0,0,0,0,0,S,0,1));   // 25 load-use
        vecs.push_back(vin(0,0,0,0,0,0,1,0,1,0,0,0,N,0,0));   // 26 halt from hold
        vecs.push_back(vin(1,0,0,0,0,0,1,0,1,0,0,0,R,1,0));   // 27 reset while halted
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 28 running after reset
        vecs.push_back(vin(0,0,0,0,0,0,1,0,1,0,0,0,S,0,1));   // 29 halt
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,1,0,S,1,0));   // 30 step
        vecs.push_back(vin(0,0,0,0,0,0,1,1,0,0,0,0,F,1,0));   // 31 branch during step
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,1,S,1,0));   // 32 resume
        vecs.push_back(vin(0,0,0,0,0,0,1,0,0,0,0,0,N,0,0));   // 33 running

        repeat (2) @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            drive(vecs[i]);
            e.ctl = vecs[i].ctl;
            e.h   = vecs[i].h;
            e.cnt = cnt_model;
            sb.push_back(e);
            if (vecs[i].rst)
                cnt_model = 16'd0;
            else if (vecs[i].stl && cnt_model != 16'hFFFF)
                cnt_model = cnt_model + 16'd1;
            @(negedge clock);
            compare_front(i);
        end

        // Long run of back-to-back loads: every other cycle is a stall
        @(posedge clock);
        #1;
        drive(idle);
        reset = 1'b1;
        @(posedge clock);
        #1;
        drive(vin(0,1,5,5,0,0,1,0,0,0,0,0,N,0,0));
        repeat (140000) @(posedge clock);
        #1;
        drive(idle);
        @(negedge clock);
        check1("stall_count_saturated", 100, stall_count, 16'hFFFF);
        check1("pc_write_after_saturation", 100, {15'd0, pc_write}, 16'd1);

        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check1("ifid_flush_in_reset", 101, {15'd0, ifid_flush}, 16'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check1("stall_count_after_reset", 102, stall_count, 16'd0);
        check1("halted_after_reset", 102, {15'd0, halted}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
